// File: rtl/fluxo_dados_n.sv
// fluxo_dados_n: datapath of the LED-matrix memory puzzle.
//
// Holds the one-hot symbol sequence memory, an LFSR used to extend the
// sequence with random symbols, the address/round counters, the play
// timeout, the display timer, press detection and the LED source mux.
// Every strobe comes from the control unit.
//
// Ports
//   clock, reset                : rising-edge clock, synchronous active-high reset
//   zeraE/contaE                : address counter clear / increment
//   zeraL/contaL                : round limit counter clear / increment
//   limpaR/registraR            : play register clear / load from botoes
//   escreveM, fonteM            : memory write, data source (0 play reg, 1 LFSR)
//   nivel                       : 0 easy end limit, 1 hard end limit
//   zeraTO/contaTO              : timeout clear / enable
//   zeraTMR/contaTMR            : display timer clear / enable
//   selLeds                     : LED source (botoes, memory, play reg, off)
//   botoes                      : synchronised buttons
//   jogadaIgualMemoria ... fimTMR, timeout : status to the control unit
//   jogada_feita, jogada_invalida         : press pulses
//   leds                        : LED drive
//   db_endereco, db_limite, db_jogada, db_memoria : debug views
module fluxo_dados_n #(
    parameter int NB             = 4,
    parameter int PROF           = 16,
    parameter int LIM_FACIL      = 7,
    parameter int LIM_DIFICIL    = 15,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int TMR_CICLOS     = 500
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     zeraE,
    input  logic                     contaE,
    input  logic                     zeraL,
    input  logic                     contaL,
    input  logic                     limpaR,
    input  logic                     registraR,
    input  logic                     escreveM,
    input  logic                     fonteM,
    input  logic                     nivel,
    input  logic                     zeraTO,
    input  logic                     contaTO,
    input  logic                     zeraTMR,
    input  logic                     contaTMR,
    input  logic [1:0]               selLeds,
    input  logic [NB-1:0]            botoes,
    output logic                     jogadaIgualMemoria,
    output logic                     enderecoIgualLimite,
    output logic                     enderecoMenorLimite,
    output logic                     fimE,
    output logic                     fimL,
    output logic                     fimTMR,
    output logic                     timeout,
    output logic                     jogada_feita,
    output logic                     jogada_invalida,
    output logic [NB-1:0]            leds,
    output logic [$clog2(PROF)-1:0]  db_endereco,
    output logic [$clog2(PROF)-1:0]  db_limite,
    output logic [NB-1:0]            db_jogada,
    output logic [NB-1:0]            db_memoria
);

    localparam int AW  = $clog2(PROF);
    localparam int TOW = $clog2(TIMEOUT_CICLOS + 1);
    localparam int TMW = $clog2(TMR_CICLOS + 1);

    localparam logic [AW-1:0]  END_MAX = AW'(PROF - 1);
    localparam logic [AW-1:0]  LIM_F   = AW'(LIM_FACIL);
    localparam logic [AW-1:0]  LIM_D   = AW'(LIM_DIFICIL);
    localparam logic [TOW-1:0] TO_MAX  = TOW'(TIMEOUT_CICLOS - 1);
    localparam logic [TMW-1:0] TMR_MAX = TMW'(TMR_CICLOS - 1);

    function automatic int f_popcount(input logic [NB-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NB; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    logic [AW-1:0]  r_end;
    logic [AW-1:0]  r_lim;
    logic [NB-1:0]  r_jogada;
    logic [NB-1:0]  r_mem [PROF];
    logic [15:0]    r_lfsr;
    logic [TOW-1:0] r_to;
    logic [TMW-1:0] r_tmr;
    logic           r_prev;

    logic [7:0]     w_idx;
    logic [NB-1:0]  w_sym;
    logic [NB-1:0]  w_dado;
    logic [NB-1:0]  w_mem;
    logic           w_fb;

    // Random symbol: low LFSR byte reduced modulo NB picks the lit button.
    assign w_idx  = 8'(32'(r_lfsr[7:0]) % NB);
    assign w_sym  = {{(NB-1){1'b0}}, 1'b1} << w_idx;
    assign w_dado = fonteM ? w_sym : r_jogada;
    assign w_mem  = r_mem[r_end];
    assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_end    <= '0;
            r_lim    <= '0;
            r_jogada <= '0;
            r_lfsr   <= 16'hACE1;
            r_to     <= '0;
            r_tmr    <= '0;
            r_prev   <= 1'b0;
        end else begin
            if (zeraE)
                r_end <= '0;
            else if (contaE)
                r_end <= (r_end == END_MAX) ? '0 : r_end + AW'(1);

            if (zeraL)
                r_lim <= '0;
            else if (contaL && r_lim != END_MAX)
                r_lim <= r_lim + AW'(1);

            if (limpaR)
                r_jogada <= '0;
            else if (registraR)
                r_jogada <= botoes;

            r_lfsr <= {r_lfsr[14:0], w_fb};

            // Saturation makes the expired state sticky; contaTO=0 pauses.
            if (zeraTO)
                r_to <= '0;
            else if (contaTO && r_to != TO_MAX)
                r_to <= r_to + TOW'(1);

            if (zeraTMR)
                r_tmr <= '0;
            else if (contaTMR)
                r_tmr <= (r_tmr == TMR_MAX) ? '0 : r_tmr + TMW'(1);

            // Clearing history at round start lets an already-held button fire.
            r_prev <= zeraL ? 1'b0 : (|botoes);
        end
    end

    // Memory: combinational read, write lands on the clock edge so a read
    // in the write cycle still sees the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PROF; i++) begin
                r_mem[i] <= '0;
            end
        end else if (escreveM) begin
            r_mem[r_end] <= w_dado;
        end
    end

    assign jogadaIgualMemoria  = (r_jogada == w_mem);
    assign enderecoIgualLimite = (r_end == r_lim);
    assign enderecoMenorLimite = (r_end < r_lim);
    assign fimE                = (r_end == END_MAX);
    assign fimL                = (r_lim == (nivel ? LIM_D : LIM_F));
    assign fimTMR              = (r_tmr == TMR_MAX);
    assign timeout             = (r_to == TO_MAX);
    assign jogada_feita        = (|botoes) & ~r_prev;
    assign jogada_invalida     = jogada_feita & (f_popcount(botoes) != 1);

    always_comb begin
        leds = '0;
        case (selLeds)
            2'b00:   leds = botoes;
            2'b01:   leds = w_mem;
            2'b10:   leds = r_jogada;
            default: leds = '0;
        endcase
    end

    assign db_endereco = r_end;
    assign db_limite   = r_lim;
    assign db_jogada   = r_jogada;
    assign db_memoria  = w_mem;

endmodule

// File: tb/tb_fluxo_dados_n.sv
module tb_fluxo_dados_n;

    localparam int NB   = 4;
    localparam int PROF = 16;
    localparam int AW   = 4;
    localparam int LF   = 7;
    localparam int LD   = 15;
    localparam int TO   = 10;
    localparam int TMR  = 5;

    logic clock = 1'b0;
    logic reset, zeraE, contaE, zeraL, contaL, limpaR, registraR;
    logic escreveM, fonteM, nivel, zeraTO, contaTO, zeraTMR, contaTMR;
    logic [1:0]    selLeds;
    logic [NB-1:0] botoes;
    logic jogadaIgualMemoria, enderecoIgualLimite, enderecoMenorLimite;
    logic fimE, fimL, fimTMR, timeout, jogada_feita, jogada_invalida;
    logic [NB-1:0] leds, db_jogada, db_memoria;
    logic [AW-1:0] db_endereco, db_limite;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state kept as plain integers.
    int m_end, m_lim, m_reg, m_lfsr, m_to, m_tmr, m_prev;
    int m_mem [PROF];

    always #5 clock = ~clock;

    fluxo_dados_n #(
        .NB(NB), .PROF(PROF), .LIM_FACIL(LF), .LIM_DIFICIL(LD),
        .TIMEOUT_CICLOS(TO), .TMR_CICLOS(TMR)
    ) dut (
        .clock(clock), .reset(reset),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .limpaR(limpaR), .registraR(registraR), .escreveM(escreveM),
        .fonteM(fonteM), .nivel(nivel), .zeraTO(zeraTO), .contaTO(contaTO),
        .zeraTMR(zeraTMR), .contaTMR(contaTMR), .selLeds(selLeds),
        .botoes(botoes),
        .jogadaIgualMemoria(jogadaIgualMemoria),
        .enderecoIgualLimite(enderecoIgualLimite),
        .enderecoMenorLimite(enderecoMenorLimite),
        .fimE(fimE), .fimL(fimL), .fimTMR(fimTMR), .timeout(timeout),
        .jogada_feita(jogada_feita), .jogada_invalida(jogada_invalida),
        .leds(leds), .db_endereco(db_endereco), .db_limite(db_limite),
        .db_jogada(db_jogada), .db_memoria(db_memoria)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int popc(input int v);
        int n;
        n = 0;
        for (int i = 0; i < NB; i++) n += (v >> i) & 1;
        return n;
    endfunction

    // Advance the reference by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        int fb;
        if (reset) begin
            m_end = 0; m_lim = 0; m_reg = 0; m_lfsr = 'hACE1;
            m_to = 0; m_tmr = 0; m_prev = 0;
            for (int i = 0; i < PROF; i++) m_mem[i] = 0;
            return;
        end
        if (escreveM)
            m_mem[m_end] = fonteM ? (1 << ((m_lfsr & 255) % NB)) : m_reg;
        if (zeraE) m_end = 0;
        else if (contaE) m_end = (m_end + 1) % PROF;
        if (zeraL) m_lim = 0;
        else if (contaL && m_lim < PROF - 1) m_lim = m_lim + 1;
        if (limpaR) m_reg = 0;
        else if (registraR) m_reg = int'(botoes);
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) & 'hFFFF) | fb;
        if (zeraTO) m_to = 0;
        else if (contaTO && m_to < TO - 1) m_to = m_to + 1;
        if (zeraTMR) m_tmr = 0;
        else if (contaTMR) m_tmr = (m_tmr + 1) % TMR;
        m_prev = zeraL ? 0 : (botoes != 0);
    endtask

    task automatic check_all();
        int b, exp_leds, press;
        b = int'(botoes);
        press = (b != 0) && (m_prev == 0);
        case (selLeds)
            2'b00:   exp_leds = b;
            2'b01:   exp_leds = m_mem[m_end];
            2'b10:   exp_leds = m_reg;
            default: exp_leds = 0;
        endcase
        chk("jogadaIgualMemoria", jogadaIgualMemoria, m_reg == m_mem[m_end]);
        chk("enderecoIgualLimite", enderecoIgualLimite, m_end == m_lim);
        chk("enderecoMenorLimite", enderecoMenorLimite, m_end < m_lim);
        chk("fimE", fimE, m_end == PROF - 1);
        chk("fimL", fimL, m_lim == (nivel ? LD : LF));
        chk("fimTMR", fimTMR, m_tmr == TMR - 1);
        chk("timeout", timeout, m_to == TO - 1);
        chk("jogada_feita", jogada_feita, press);
        chk("jogada_invalida", jogada_invalida, press && popc(b) != 1);
        chk("leds", leds, exp_leds);
        chk("db_endereco", db_endereco, m_end);
        chk("db_limite", db_limite, m_lim);
        chk("db_jogada", db_jogada, m_reg);
        chk("db_memoria", db_memoria, m_mem[m_end]);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic idle();
        zeraE = 0; contaE = 0; zeraL = 0; contaL = 0; limpaR = 0; registraR = 0;
        escreveM = 0; fonteM = 0; zeraTO = 0; contaTO = 0; zeraTMR = 0; contaTMR = 0;
    endtask

    initial begin
        int pulses;
        idle();
        reset = 1; nivel = 0; selLeds = 2'b00; botoes = '0;
        for (int i = 0; i < PROF; i++) m_mem[i] = 0;
        m_end = 0; m_lim = 0; m_reg = 0; m_lfsr = 0; m_to = 0; m_tmr = 0; m_prev = 0;
        tick(); tick();

        // Reset values as absolute constants
        chk("rst_jim", jogadaIgualMemoria, 1);
        chk("rst_eil", enderecoIgualLimite, 1);
        chk("rst_eml", enderecoMenorLimite, 0);
        chk("rst_fimE", fimE, 0);
        chk("rst_fimL", fimL, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_jf", jogada_feita, 0);
        chk("rst_dbmem", db_memoria, 0);

        // First LFSR write right after reset: 0xE1 % 4 = 1
        reset = 0; escreveM = 1; fonteM = 1;
        tick();
        idle();
        chk("lfsr_first_word", db_memoria, 4'b0010);

        // Record a play value at address 3 and compare it back
        botoes = 4'b0100; registraR = 1; tick();
        idle(); botoes = '0;
        contaE = 1; tick(); tick(); tick();
        idle();
        chk("rec_addr", db_endereco, 3);
        escreveM = 1; fonteM = 0; tick();
        idle();
        chk("rec_mem", db_memoria, 4'b0100);
        chk("rec_equal", jogadaIgualMemoria, 1);
        botoes = 4'b0010; registraR = 1; tick();
        idle(); botoes = '0;
        chk("rec_differ", jogadaIgualMemoria, 0);
        selLeds = 2'b01; settle();
        chk("leds_mem", leds, 4'b0100);
        selLeds = 2'b11; settle();
        chk("leds_off", leds, 0);
        selLeds = 2'b00;

        // Limits and address wrap
        zeraL = 1; tick(); idle();
        nivel = 0; contaL = 1;
        for (int i = 0; i < 7; i++) tick();
        idle();
        chk("fimL_facil", fimL, 1);
        nivel = 1; settle();
        chk("fimL_dificil_early", fimL, 0);
        contaL = 1;
        for (int i = 0; i < 8; i++) tick();
        idle();
        chk("fimL_dificil", fimL, 1);
        contaL = 1;
        for (int i = 0; i < 20; i++) tick();
        idle();
        chk("lim_saturate", db_limite, 15);
        zeraE = 1; tick(); idle();
        contaE = 1;
        for (int i = 0; i < 15; i++) tick();
        idle();
        chk("fimE_at15", fimE, 1);
        contaE = 1; tick(); idle();
        chk("addr_wrap", db_endereco, 0);

        // Timeout: 5 counting, 20 paused, 4 counting
        zeraTO = 1; tick(); idle();
        contaTO = 1; for (int i = 0; i < 5; i++) tick();
        contaTO = 0; for (int i = 0; i < 20; i++) tick();
        chk("to_paused", timeout, 0);
        contaTO = 1; for (int i = 0; i < 4; i++) tick();
        chk("to_expired", timeout, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("to_sticky", timeout, 1);
        zeraTO = 1; tick();
        chk("to_cleared", timeout, 0);
        for (int i = 0; i < 3; i++) tick();
        zeraTO = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("to_from_zero_8", timeout, 0);
        tick();
        chk("to_from_zero_9", timeout, 1);
        idle();

        // Display timer wraps every 5 cycles
        zeraTMR = 1; tick(); idle();
        contaTMR = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("tmr_end", fimTMR, 1);
        tick();
        chk("tmr_wrap", fimTMR, 0);
        idle();

        // Press detection
        botoes = '0; tick();
        botoes = 4'b0001; settle();
        pulses = int'(jogada_feita);
        chk("press_valid", jogada_invalida, 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            pulses += int'(jogada_feita);
        end
        chk("press_pulses", pulses, 1);
        botoes = '0; tick();
        botoes = 4'b0011; settle();
        chk("multi_jf", jogada_feita, 1);
        chk("multi_ji", jogada_invalida, 1);
        tick();
        chk("multi_jf_once", jogada_feita, 0);
        // Held button across zeraL fires again
        zeraL = 1; tick(); idle();
        chk("held_refire", jogada_feita, 1);
        botoes = '0;

        // Randomized traffic against the reference
        for (int c = 0; c < 3000; c++) begin
            zeraE     = ($urandom_range(0, 19) == 0);
            contaE    = ($urandom_range(0, 2) == 0);
            zeraL     = ($urandom_range(0, 24) == 0);
            contaL    = ($urandom_range(0, 3) == 0);
            limpaR    = ($urandom_range(0, 19) == 0);
            registraR = ($urandom_range(0, 3) == 0);
            escreveM  = ($urandom_range(0, 2) == 0);
            fonteM    = 1'($urandom_range(0, 1));
            nivel     = 1'($urandom_range(0, 1));
            zeraTO    = ($urandom_range(0, 29) == 0);
            contaTO   = ($urandom_range(0, 2) != 0);
            zeraTMR   = ($urandom_range(0, 19) == 0);
            contaTMR  = ($urandom_range(0, 3) != 0);
            selLeds   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                botoes = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom_range(1, 15));
            tick();
        end
        idle(); botoes = '0; selLeds = 2'b00;

        // Mid-activity reset clears counters and every memory word
        contaTO = 1; contaE = 1; contaL = 1; tick();
        idle();
        reset = 1; tick(); reset = 0;
        chk("mid_rst_end", db_endereco, 0);
        chk("mid_rst_lim", db_limite, 0);
        chk("mid_rst_to", timeout, 0);
        for (int i = 0; i < PROF; i++) begin
            chk("mid_rst_mem", db_memoria, 0);
            contaE = 1; tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
